pc_fetch_stage: RTL and testbench
=================================

// Module: pc_fetch_stage
// PURPOSE
//  Program-counter register and IF/ID pipeline latch of the five-stage pipeline.
//  - Each clock it loads the next-PC value computed by the next-PC logic.
//  - It drives the instruction-memory address.
//  - It latches {PC, instruction, valid} into IF/ID for decode, and applies stall, flush and halt.
//  - It returns the current PC to the next-PC logic, closing the PC loop.
// PARAMETERS
//  PC_W      32  width of the word-addressed PC; next_pc, pc, id_pc use this width
//  IMEM_AW   10  instruction-memory address width; imem_addr = pc[IMEM_AW-1:0]
//  RESET_PC  0   PC value loaded on reset
//  CNT_W     32  width of the performance counters
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous reset, active-high
//  next_pc      in   PC_W     next PC from next-PC logic (already holds PC when halting)
//  stall        in   1        load-use hazard: hold PC and IF/ID
//  flush        in   1        taken jump/branch resolved: discard the instruction in IF
//  halt         in   1        halt request (syscall decoded); sticky until reset
//  imem_inst    in   32       instruction word; combinational read of imem_addr
//  imem_addr    out  IMEM_AW  instruction-memory word address
//  pc           out  PC_W     current PC (to next-PC logic and branch offset adder)
//  id_pc        out  PC_W     PC of the instruction held in IF/ID
//  id_inst      out  32       instruction held in IF/ID (0x00000000 = NOP bubble)
//  id_valid     out  1        IF/ID holds a real instruction
//  halted       out  1        fetch frozen by halt
//  fetch_count  out  CNT_W    instructions delivered into IF/ID
//  flush_count  out  CNT_W    instructions discarded by flush
// BEHAVIOUR
//  Reset (async, immediate): all outputs take these values, from any state, including mid-stall or while halted.
//    pc=RESET_PC, id_pc=0, id_inst=0, id_valid=0, halted=0, both counters=0.
//  Priority per rising edge: halted > halt > flush > stall > normal.
//  - halted=1: every register holds; inputs ignored.
//  - halt=1 (halted=0): halted<=1, pc holds, IF/ID <= bubble {0,0,0}.
//      Counters do not change on the halt edge.
//  - flush=1: pc<=next_pc, IF/ID <= bubble, flush_count+1.
//      Flush overrides a same-cycle stall; the redirect target is never lost.
//  - stall=1: pc and IF/ID hold; counters unchanged.
//  - normal: pc<=next_pc, IF/ID <= {pc, imem_inst, 1}, fetch_count+1.
//  Latency: an instruction at PC=p appears in IF/ID one cycle after pc==p.
//    The first fetch after reset is visible one edge after rst deasserts.
//  imem_addr is combinational from pc (truncated to IMEM_AW); no width checks.
//  next_pc is loaded unmodified; PC wrap-around is the next-PC logic's concern.
//  Counters saturate at all-ones; no wrap.
//  Stall held for N cycles: IF/ID and pc are stable for N cycles.
//    The fetch then resumes with the same pc and no duplicate count.
// TESTING
//  1. Reset, next_pc=pc+1, 4 cycles -> id_pc 0,1,2,3 with the matching
//     instructions, id_valid=1 from cycle 1, fetch_count=4.
//  2. stall=1 for 2 cycles at pc=5 -> pc stays 5, id_pc stays 4, fetch_count unchanged.
//     Then release -> id_pc=5 next edge.
//  3. flush=1 with next_pc=0x20 at pc=7 -> next edge: pc=0x20, id_valid=0, id_inst=0,
//     flush_count=1; following edge id_pc=0x20.
//  4. flush=1 and stall=1 together with next_pc=0x40 -> pc=0x40, bubble in IF/ID,
//     flush_count+1 (flush wins).
//  5. halt=1 at pc=9 -> halted=1, pc=9, id_valid=0.
//     Then 10 cycles of toggling flush/stall -> nothing changes.
//  6. rst pulse asserted between clock edges during a stall -> outputs reset immediately.
//     Counter saturation is checked with CNT_W=4: 20 fetches -> fetch_count=15.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Program-counter register and IF/ID pipeline latch for the five-stage pipeline.
// Applies halt > flush > stall > normal each edge and keeps saturating fetch/flush counters.
module pc_fetch_stage #(
    parameter int              PC_W     = 32,
    parameter int              IMEM_AW  = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    next_pc,
    input  logic               stall,
    input  logic               flush,
    input  logic               halt,
    input  logic [31:0]        imem_inst,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    id_pc,
    output logic [31:0]        id_inst,
    output logic               id_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   flush_count
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_e;

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   id_pc_q, id_pc_d;
    logic [31:0]       id_inst_q, id_inst_d;
    logic              id_valid_q, id_valid_d;
    logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        id_valid_d  = id_valid_q;
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_HALTED: begin
                // Frozen until reset; all inputs are ignored.
            end
            default: begin
                if (halt) begin
                    state_d    = ST_HALTED;
                    id_pc_d    = '0;
                    id_inst_d  = '0;
                    id_valid_d = 1'b0;
                end else if (flush) begin
                    // Flush beats a same-cycle stall so the redirect target is never dropped.
                    pc_d        = next_pc;
                    id_pc_d     = '0;
                    id_inst_d   = '0;
                    id_valid_d  = 1'b0;
                    flush_cnt_d = sat_inc(flush_cnt_q);
                end else if (!stall) begin
                    pc_d        = next_pc;
                    id_pc_d     = pc_q;
                    id_inst_d   = imem_inst;
                    id_valid_d  = 1'b1;
                    fetch_cnt_d = sat_inc(fetch_cnt_q);
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            id_pc_q     <= '0;
            id_inst_q   <= '0;
            id_valid_q  <= 1'b0;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            id_valid_q  <= id_valid_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW-1:0];
    assign pc          = pc_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign id_valid    = id_valid_q;
    assign halted      = (state_q == ST_HALTED);
    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: sequential fetch, stall, flush, halt, async reset
// and counter saturation on a second instance with 4-bit counters.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, halt;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc, pc, id_pc, id_inst, imem_inst;
    logic [9:0]  imem_addr;
    logic        id_valid, halted;
    logic [31:0] fetch_count, flush_count;

    logic        s_rst;
    logic [31:0] s_next_pc, s_pc, s_id_pc, s_id_inst, s_imem_inst;
    logic [9:0]  s_imem_addr;
    logic        s_id_valid, s_halted;
    logic [3:0]  s_fetch_count, s_flush_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {22'd0, a[9:0]};
    endfunction

    assign imem_inst   = inst_of({22'd0, imem_addr});
    assign next_pc     = redirect ? target : pc + 32'd1;
    assign s_imem_inst = inst_of({22'd0, s_imem_addr});
    assign s_next_pc   = s_pc + 32'd1;

    pc_fetch_stage dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .stall(stall), .flush(flush), .halt(halt),
        .imem_inst(imem_inst), .imem_addr(imem_addr), .pc(pc), .id_pc(id_pc),
        .id_inst(id_inst), .id_valid(id_valid), .halted(halted),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    pc_fetch_stage #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(s_rst), .next_pc(s_next_pc), .stall(1'b0), .flush(1'b0), .halt(1'b0),
        .imem_inst(s_imem_inst), .imem_addr(s_imem_addr), .pc(s_pc), .id_pc(s_id_pc),
        .id_inst(s_id_inst), .id_valid(s_id_valid), .halted(s_halted),
        .fetch_count(s_fetch_count), .flush_count(s_flush_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL reset_id_pc got=%0h exp=0", id_pc); end
        checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL reset_id_inst got=%0h exp=0", id_inst); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_fetch_count got=%0d exp=0", fetch_count); end
        checks++; if (flush_count !== 32'd0) begin failures++; $display("FAIL reset_flush_count got=%0d exp=0", flush_count); end
        checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL reset_imem_addr got=%0h exp=0", imem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (id_pc !== 32'(k - 1)) begin failures++; $display("FAIL seq_id_pc[%0d] got=%0h exp=%0h", k, id_pc, k - 1); end
            checks++; if (id_inst !== inst_of(32'(k - 1))) begin failures++; $display("FAIL seq_id_inst[%0d] got=%0h exp=%0h", k, id_inst, inst_of(32'(k - 1))); end
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL seq_id_valid[%0d] got=%0b exp=1", k, id_valid); end
            checks++; if (pc !== 32'(k)) begin failures++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", k, pc, k); end
            checks++; if (fetch_count !== 32'(k)) begin failures++; $display("FAIL seq_fetch_count[%0d] got=%0d exp=%0d", k, fetch_count, k); end
        end
        step();
        checks++; if (pc !== 32'd5) begin failures++; $display("FAIL seq_pc5 got=%0h exp=5", pc); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (pc !== 32'd5) begin failures++; $display("FAIL stall_pc[%0d] got=%0h exp=5", k, pc); end
            checks++; if (id_pc !== 32'd4) begin failures++; $display("FAIL stall_id_pc[%0d] got=%0h exp=4", k, id_pc); end
            checks++; if (id_inst !== inst_of(32'd4)) begin failures++; $display("FAIL stall_id_inst[%0d] got=%0h exp=%0h", k, id_inst, inst_of(32'd4)); end
            checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL stall_fetch_count[%0d] got=%0d exp=5", k, fetch_count); end
        end
        stall = 1'b0;
        step();
        checks++; if (id_pc !== 32'd5) begin failures++; $display("FAIL stall_release_id_pc got=%0h exp=5", id_pc); end
        checks++; if (pc !== 32'd6) begin failures++; $display("FAIL stall_release_pc got=%0h exp=6", pc); end
        checks++; if (fetch_count !== 32'd6) begin failures++; $display("FAIL stall_release_fetch_count got=%0d exp=6", fetch_count); end
        step();
        checks++; if (pc !== 32'd7) begin failures++; $display("FAIL stall_pc7 got=%0h exp=7", pc); end
    endtask

    task automatic test_flush();
        redirect = 1'b1; target = 32'h20; flush = 1'b1;
        step();
        checks++; if (pc !== 32'h20) begin failures++; $display("FAIL flush_pc got=%0h exp=20", pc); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_id_valid got=%0b exp=0", id_valid); end
        checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL flush_id_inst got=%0h exp=0", id_inst); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL flush_id_pc got=%0h exp=0", id_pc); end
        checks++; if (flush_count !== 32'd1) begin failures++; $display("FAIL flush_count got=%0d exp=1", flush_count); end
        checks++; if (fetch_count !== 32'd7) begin failures++; $display("FAIL flush_fetch_count got=%0d exp=7", fetch_count); end
        flush = 1'b0; redirect = 1'b0;
        step();
        checks++; if (id_pc !== 32'h20) begin failures++; $display("FAIL flush_next_id_pc got=%0h exp=20", id_pc); end
        checks++; if (id_inst !== inst_of(32'h20)) begin failures++; $display("FAIL flush_next_id_inst got=%0h exp=%0h", id_inst, inst_of(32'h20)); end
        checks++; if (pc !== 32'h21) begin failures++; $display("FAIL flush_next_pc got=%0h exp=21", pc); end
        checks++; if (fetch_count !== 32'd8) begin failures++; $display("FAIL flush_next_fetch_count got=%0d exp=8", fetch_count); end
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; target = 32'h40; flush = 1'b1; stall = 1'b1;
        step();
        checks++; if (pc !== 32'h40) begin failures++; $display("FAIL fs_pc got=%0h exp=40", pc); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fs_id_valid got=%0b exp=0", id_valid); end
        checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL fs_id_inst got=%0h exp=0", id_inst); end
        checks++; if (flush_count !== 32'd2) begin failures++; $display("FAIL fs_flush_count got=%0d exp=2", flush_count); end
        checks++; if (fetch_count !== 32'd8) begin failures++; $display("FAIL fs_fetch_count got=%0d exp=8", fetch_count); end
        flush = 1'b0; stall = 1'b0; target = 32'd9;
        step();
        checks++; if (pc !== 32'd9) begin failures++; $display("FAIL redirect_pc got=%0h exp=9", pc); end
        checks++; if (id_pc !== 32'h40) begin failures++; $display("FAIL redirect_id_pc got=%0h exp=40", id_pc); end
        checks++; if (fetch_count !== 32'd9) begin failures++; $display("FAIL redirect_fetch_count got=%0d exp=9", fetch_count); end
        redirect = 1'b0;
    endtask

    task automatic test_halt();
        halt = 1'b1;
        step();
        halt = 1'b0;
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%0b exp=1", halted); end
        checks++; if (pc !== 32'd9) begin failures++; $display("FAIL halt_pc got=%0h exp=9", pc); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL halt_id_valid got=%0b exp=0", id_valid); end
        checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL halt_id_inst got=%0h exp=0", id_inst); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL halt_id_pc got=%0h exp=0", id_pc); end
        checks++; if (fetch_count !== 32'd9) begin failures++; $display("FAIL halt_fetch_count got=%0d exp=9", fetch_count); end
        checks++; if (flush_count !== 32'd2) begin failures++; $display("FAIL halt_flush_count got=%0d exp=2", flush_count); end
        redirect = 1'b1;
        for (int i = 0; i < 10; i++) begin
            flush = i[0]; stall = i[1]; target = 32'h100 + 32'(i);
            step();
            checks++; if (pc !== 32'd9) begin failures++; $display("FAIL halted_pc[%0d] got=%0h exp=9", i, pc); end
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halted_flag[%0d] got=%0b exp=1", i, halted); end
            checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL halted_id_valid[%0d] got=%0b exp=0", i, id_valid); end
            checks++; if (fetch_count !== 32'd9) begin failures++; $display("FAIL halted_fetch_count[%0d] got=%0d exp=9", i, fetch_count); end
            checks++; if (flush_count !== 32'd2) begin failures++; $display("FAIL halted_flush_count[%0d] got=%0d exp=2", i, flush_count); end
        end
        flush = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_async_reset();
        #3 rst = 1'b1;
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL arst_halted got=%0b exp=0", halted); end
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL arst_halt_pc got=%0h exp=0", pc); end
        checks++; if (flush_count !== 32'd0) begin failures++; $display("FAIL arst_flush_count got=%0d exp=0", flush_count); end
        #1 rst = 1'b0;
        step();
        checks++; if (pc !== 32'd1) begin failures++; $display("FAIL arst_first_pc got=%0h exp=1", pc); end
        checks++; if (id_pc !== 32'd0 || id_valid !== 1'b1) begin failures++; $display("FAIL arst_first_fetch got=%0h/%0b exp=0/1", id_pc, id_valid); end
        step();
        stall = 1'b1;
        step();
        checks++; if (pc !== 32'd2 || id_pc !== 32'd1) begin failures++; $display("FAIL arst_stall got=%0h/%0h exp=2/1", pc, id_pc); end
        #3 rst = 1'b1;
        #1;
        checks++; if (pc !== 32'd0) begin failures++; $display("FAIL arst_pc got=%0h exp=0", pc); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL arst_id_pc got=%0h exp=0", id_pc); end
        checks++; if (id_inst !== 32'd0) begin failures++; $display("FAIL arst_id_inst got=%0h exp=0", id_inst); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL arst_id_valid got=%0b exp=0", id_valid); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL arst_fetch_count got=%0d exp=0", fetch_count); end
        stall = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        s_rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp_cnt = (k > 15) ? 4'd15 : 4'(k);
            checks++; if (s_fetch_count !== exp_cnt) begin failures++; $display("FAIL sat_fetch_count[%0d] got=%0d exp=%0d", k, s_fetch_count, exp_cnt); end
        end
        checks++; if (s_pc !== 32'd20) begin failures++; $display("FAIL sat_pc got=%0d exp=20", s_pc); end
        checks++; if (s_id_pc !== 32'd19 || s_id_valid !== 1'b1) begin failures++; $display("FAIL sat_id got=%0d/%0b exp=19/1", s_id_pc, s_id_valid); end
        checks++; if (s_id_inst !== inst_of(32'd19)) begin failures++; $display("FAIL sat_id_inst got=%0h exp=%0h", s_id_inst, inst_of(32'd19)); end
        checks++; if (s_flush_count !== 4'd0 || s_halted !== 1'b0) begin failures++; $display("FAIL sat_idle got=%0d/%0b exp=0/0", s_flush_count, s_halted); end
    endtask

    initial begin
        rst = 1'b1; s_rst = 1'b1;
        stall = 1'b0; flush = 1'b0; halt = 1'b0;
        redirect = 1'b0; target = 32'd0;
        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_back_to_back();
        test_halt();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
